// File: rtl/locked_reg_pkg.sv
// Shared definitions for the lockable register bank (read-side responder and write-side bank).
package locked_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RESP  = 2'd2
    } rd_state_t;

    localparam int DEF_NUM_REGS = 4;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 2;
    localparam int DEF_CNT_W    = 8;

endpackage

// File: rtl/locked_reg_lock_tracker.sv
// Sticky per-register lock vector: a lock pulse sets its bit, only reset clears it.
module lock_tracker #(
    parameter int NUM_REGS = locked_reg_pkg::DEF_NUM_REGS
) (
    input  logic                Clk,
    input  logic                resetn,
    input  logic [NUM_REGS-1:0] lock_set,
    output logic [NUM_REGS-1:0] lock_status
);

    logic [NUM_REGS-1:0] r_lock_status;

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            r_lock_status <= '0;
        end else begin
            r_lock_status <= r_lock_status | lock_set;
        end
    end

    assign lock_status = r_lock_status;

endmodule

// File: rtl/locked_reg_read_port.sv
// Read-side responder: one outstanding read, denies locked or out-of-range registers,
// counts denials in a saturating counter.
module locked_reg_read_port
    import locked_reg_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                       Clk,
    input  logic                       resetn,
    input  logic [NUM_REGS*DATA_W-1:0] reg_data,
    input  logic [NUM_REGS-1:0]        lock_set,
    input  logic                       scan_mode,
    input  logic                       debug_unlocked,
    input  logic                       rd_req_valid,
    output logic                       rd_req_ready,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_resp_valid,
    input  logic                       rd_resp_ready,
    output logic [DATA_W-1:0]          rd_resp_data,
    output logic                       rd_resp_err,
    output logic [NUM_REGS-1:0]        lock_status,
    output logic [CNT_W-1:0]           deny_count
);

    rd_state_t          r_state;
    rd_state_t          w_state_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_resp_data;
    logic               r_resp_err;
    logic [CNT_W-1:0]   r_deny_count;

    logic               w_in_range;
    logic               w_locked_eff;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_deny;
    logic               w_resp_done;

    // Mode indications are deliberately kept out of every access decision.
    logic w_unused_modes;
    assign w_unused_modes = scan_mode ^ debug_unlocked;

    lock_tracker #(
        .NUM_REGS (NUM_REGS)
    ) u_lock_tracker (
        .Clk         (Clk),
        .resetn      (resetn),
        .lock_set    (lock_set),
        .lock_status (lock_status)
    );

    // State register
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (rd_req_valid) w_state_next = ST_CHECK;
            ST_CHECK: w_state_next = ST_RESP;
            ST_RESP:  if (rd_resp_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rd_req_ready  = 1'b0;
        rd_resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: rd_req_ready  = 1'b1;
            ST_RESP: rd_resp_valid = 1'b1;
            default: ;
        endcase
    end

    // A lock pulse landing in the CHECK cycle already counts as locked.
    always_comb begin
        w_in_range   = 1'b0;
        w_locked_eff = 1'b0;
        w_sel_data   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_addr == ADDR_W'(i)) begin
                w_in_range   = 1'b1;
                w_locked_eff = lock_status[i] | lock_set[i];
                w_sel_data   = reg_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_deny      = !w_in_range || w_locked_eff;
    assign w_resp_done = (r_state == ST_RESP) && rd_resp_ready;

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            r_addr <= '0;
        end else if ((r_state == ST_IDLE) && rd_req_valid) begin
            r_addr <= rd_addr;
        end
    end

    // Response is captured once in CHECK and held untouched until the handshake.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else if (r_state == ST_CHECK) begin
            r_resp_data <= w_deny ? '0 : w_sel_data;
            r_resp_err  <= w_deny;
        end else if (w_resp_done) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            r_deny_count <= '0;
        end else if ((r_state == ST_CHECK) && w_deny && (r_deny_count != {CNT_W{1'b1}})) begin
            r_deny_count <= r_deny_count + CNT_W'(1);
        end
    end

    assign rd_resp_data = r_resp_data;
    assign rd_resp_err  = r_resp_err;
    assign deny_count   = r_deny_count;

endmodule

// File: tb/tb_locked_reg_read_port.sv
// Directed plus randomized reads against a behavioural model of lock, deny and counter rules.
module tb_locked_reg_read_port;

    localparam int NUM_REGS = 3;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 2;
    localparam int CNT_W    = 3;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                       Clk;
    logic                       resetn;
    logic [NUM_REGS*DATA_W-1:0] reg_data;
    logic [NUM_REGS-1:0]        lock_set;
    logic                       scan_mode;
    logic                       debug_unlocked;
    logic                       rd_req_valid;
    logic                       rd_req_ready;
    logic [ADDR_W-1:0]          rd_addr;
    logic                       rd_resp_valid;
    logic                       rd_resp_ready;
    logic [DATA_W-1:0]          rd_resp_data;
    logic                       rd_resp_err;
    logic [NUM_REGS-1:0]        lock_status;
    logic [CNT_W-1:0]           deny_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W-1:0] regs [NUM_REGS];
    bit                lock_model [NUM_REGS];
    int                count_model;

    locked_reg_read_port #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W)
    ) dut (
        .Clk            (Clk),
        .resetn         (resetn),
        .reg_data       (reg_data),
        .lock_set       (lock_set),
        .scan_mode      (scan_mode),
        .debug_unlocked (debug_unlocked),
        .rd_req_valid   (rd_req_valid),
        .rd_req_ready   (rd_req_ready),
        .rd_addr        (rd_addr),
        .rd_resp_valid  (rd_resp_valid),
        .rd_resp_ready  (rd_resp_ready),
        .rd_resp_data   (rd_resp_data),
        .rd_resp_err    (rd_resp_err),
        .lock_status    (lock_status),
        .deny_count     (deny_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lock_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) v[i] = lock_model[i];
        return v;
    endfunction

    task automatic drive_regs();
        for (int i = 0; i < NUM_REGS; i++) reg_data[i*DATA_W +: DATA_W] = regs[i];
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_lock(input int idx);
        lock_set[idx] = 1'b1;
        step();
        lock_set = '0;
        lock_model[idx] = 1'b1;
        check("lock_status_after_pulse", 32'(lock_status), lock_vec());
    endtask

    // One full read: handshake, CHECK, RESP with 'stall' cycles of backpressure.
    task automatic do_read(input int a, input int stall, input bit race);
        logic [DATA_W-1:0] exp_data;
        bit                exp_err;
        rd_addr      = a[ADDR_W-1:0];
        rd_req_valid = 1'b1;
        check("req_ready_idle", 32'(rd_req_ready), 32'd1);
        step();
        rd_req_valid = 1'b0;
        if (race && a < NUM_REGS) lock_set[a] = 1'b1;
        if (a >= NUM_REGS) exp_err = 1'b1;
        else               exp_err = lock_model[a] || race;
        exp_data = exp_err ? '0 : regs[a];
        if (exp_err && count_model < CNT_MAX) count_model++;
        check("req_ready_check", 32'(rd_req_ready), 32'd0);
        check("resp_valid_check", 32'(rd_resp_valid), 32'd0);
        step();
        lock_set = '0;
        if (race && a < NUM_REGS) lock_model[a] = 1'b1;
        check("resp_valid_n2", 32'(rd_resp_valid), 32'd1);
        check("resp_data", 32'(rd_resp_data), 32'(exp_data));
        check("resp_err", 32'(rd_resp_err), 32'(exp_err));
        check("deny_count", 32'(deny_count), 32'(count_model));
        check("lock_status", 32'(lock_status), lock_vec());
        for (int s = 0; s < stall; s++) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'($urandom);
            drive_regs();
            step();
            check("hold_valid", 32'(rd_resp_valid), 32'd1);
            check("hold_data", 32'(rd_resp_data), 32'(exp_data));
            check("hold_err", 32'(rd_resp_err), 32'(exp_err));
            check("hold_req_ready", 32'(rd_req_ready), 32'd0);
        end
        rd_resp_ready = 1'b1;
        step();
        rd_resp_ready = 1'b0;
        check("done_valid", 32'(rd_resp_valid), 32'd0);
        check("done_data", 32'(rd_resp_data), 32'd0);
        check("done_err", 32'(rd_resp_err), 32'd0);
        check("done_req_ready", 32'(rd_req_ready), 32'd1);
        $display("read addr=%0d stall=%0d race=%0d exp_err=%0d exp_data=%04h count=%0d",
                 a, stall, race, exp_err, exp_data, count_model);
    endtask

    initial begin
        resetn         = 1'b0;
        lock_set       = '0;
        scan_mode      = 1'b0;
        debug_unlocked = 1'b0;
        rd_req_valid   = 1'b0;
        rd_addr        = '0;
        rd_resp_ready  = 1'b0;
        count_model    = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i]       = DATA_W'(16'h1000 + i);
            lock_model[i] = 1'b0;
        end
        drive_regs();

        repeat (3) step();
        check("rst_resp_valid", 32'(rd_resp_valid), 32'd0);
        check("rst_resp_data", 32'(rd_resp_data), 32'd0);
        check("rst_resp_err", 32'(rd_resp_err), 32'd0);
        check("rst_lock_status", 32'(lock_status), 32'd0);
        check("rst_deny_count", 32'(deny_count), 32'd0);
        resetn = 1'b1;
        step();
        check("rst_req_ready", 32'(rd_req_ready), 32'd1);

        // Unlocked read
        regs[2] = 16'hA5A5;
        drive_regs();
        do_read(2, 0, 1'b0);

        // Locked read with bypass modes asserted
        regs[1] = 16'h1234;
        drive_regs();
        pulse_lock(1);
        scan_mode      = 1'b1;
        debug_unlocked = 1'b1;
        do_read(1, 0, 1'b0);

        // Lock pulse arriving in the CHECK cycle
        do_read(2, 0, 1'b1);
        check("race_lock_sticky", 32'(lock_status[2]), 32'd1);
        scan_mode      = 1'b0;
        debug_unlocked = 1'b0;

        // Backpressure with changing register contents
        regs[0] = 16'h5A5A;
        drive_regs();
        do_read(0, 5, 1'b0);

        // Out-of-range address
        do_read(3, 1, 1'b0);

        // Randomized reads; the counter saturates along the way
        for (int t = 0; t < 40; t++) begin
            scan_mode      = 1'($urandom);
            debug_unlocked = 1'($urandom);
            if ($urandom_range(0, 9) == 0) pulse_lock(int'($urandom_range(0, NUM_REGS - 1)));
            for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'($urandom);
            drive_regs();
            do_read(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    $urandom_range(0, 7) == 0);
        end
        check("count_saturated", 32'(deny_count), 32'(CNT_MAX));

        // Reset while a response is pending
        rd_addr      = 2'd3;
        rd_req_valid = 1'b1;
        step();
        rd_req_valid = 1'b0;
        step();
        check("pre_reset_valid", 32'(rd_resp_valid), 32'd1);
        resetn = 1'b0;
        #1;
        check("async_rst_valid", 32'(rd_resp_valid), 32'd0);
        check("async_rst_lock", 32'(lock_status), 32'd0);
        check("async_rst_count", 32'(deny_count), 32'd0);
        check("async_rst_data", 32'(rd_resp_data), 32'd0);
        $display("reset asserted mid-response");
        step();
        resetn      = 1'b1;
        count_model = 0;
        for (int i = 0; i < NUM_REGS; i++) lock_model[i] = 1'b0;
        step();

        // Previously locked register is readable again after reset
        regs[1] = 16'hBEEF;
        drive_regs();
        do_read(1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
